vtdl_mt: RTL and testbench

- Multi-tap variable delay line built as a circular buffer. Successor to the single-tap shift-register delay line.
- Each sample written while ce is high can be read back through NTAP independent variable taps.
- Each tap has a valid flag, driven from a fill counter, so unwritten locations are never exposed.
- Used for rate control, fifo look-behind and aligning multi-stage pipelines where several delays of one bus are needed at once.

---
 rtl/vtdl_mt.sv | 95 +++++++++
 tb/tb_vtdl_mt.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtdl_mt.sv
// Multi-tap variable delay line on a circular buffer; taps gated by a fill count.
// Latency: taps combinational (OREG=0) or one clk (OREG=1); no backpressure, writes gated by ce.
module vtdl_mt #(
  parameter  int WID  = 8,
  parameter  int DEP  = 16,
  parameter  int NTAP = 2,
  parameter  int OREG = 0,
  localparam int AW   = $clog2(DEP)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 clr,
  input  logic [WID-1:0]       d,
  input  logic [NTAP*AW-1:0]   a,
  output logic [NTAP*WID-1:0]  q,
  output logic [NTAP-1:0]      qv,
  output logic [AW:0]          fill,
  output logic                 full
);

  localparam logic [AW:0]   DEPW = (AW+1)'(DEP);
  localparam logic [AW:0]   ONEW = (AW+1)'(1);
  localparam logic [AW-1:0] LAST = AW'(DEP-1);

  logic [WID-1:0]      mem [DEP];
  logic [AW-1:0]       wp;
  logic [AW:0]         cnt;
  logic [NTAP*WID-1:0] qc;
  logic [NTAP-1:0]     qvc;
  logic [AW:0]         ak;
  logic [AW:0]         idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      cnt <= '0;
    end else if (ce) begin
      wp <= (wp == LAST) ? '0 : wp + AW'(1);
      if (cnt != DEPW)
        cnt <= cnt + ONEW;
    end
  end

  // Array is left unreset; the fill count keeps stale entries hidden.
  always_ff @(posedge clk) begin
    if (ce && !clr)
      mem[wp] <= d;
  end

  always_comb begin
    qc  = '0;
    qvc = '0;
    ak  = '0;
    idx = '0;
    for (int k = 0; k < NTAP; k++) begin
      ak = {1'b0, a[k*AW +: AW]};
      // Tap 0 is the newest sample, so step back one from the write pointer.
      if ({1'b0, wp} > ak)
        idx = {1'b0, wp} - ONEW - ak;
      else
        idx = {1'b0, wp} + DEPW - ONEW - ak;
      qvc[k] = (ak < cnt) && (ak < DEPW);
      if (qvc[k])
        qc[k*WID +: WID] = mem[idx[AW-1:0]];
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q  <= '0;
          qv <= '0;
        end else if (clr) begin
          q  <= '0;
          qv <= '0;
        end else begin
          q  <= qc;
          qv <= qvc;
        end
      end
    end else begin : g_comb
      assign q  = qc;
      assign qv = qvc;
    end
  endgenerate

  assign fill = cnt;
  assign full = (cnt == DEPW);

endmodule

// File: tb/tb_vtdl_mt.sv
// Four delay-line instances (DEP 16/12/16-registered/5) share one input stream;
// an age-ordered history model predicts every tap and a monitor scores outputs.
module tb_vtdl_mt;

  typedef struct packed {
    logic [3:0][1:0][7:0] q;
    logic [3:0][1:0]      qv;
    logic [3:0][4:0]      fill;
    logic [3:0]           full;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] a_a = '0, a_b = '0, a_c = '0;
  logic [5:0] a_d = '0;
  logic [15:0] q_a, q_b, q_c, q_d;
  logic [1:0]  qv_a, qv_b, qv_c, qv_d;
  logic [4:0]  fill_a, fill_b, fill_c;
  logic [3:0]  fill_d;
  logic        full_a, full_b, full_c, full_d;

  vtdl_mt #(.WID(8), .DEP(16), .NTAP(2), .OREG(0)) u_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .d(d), .a(a_a),
    .q(q_a), .qv(qv_a), .fill(fill_a), .full(full_a));
  vtdl_mt #(.WID(8), .DEP(12), .NTAP(2), .OREG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .d(d), .a(a_b),
    .q(q_b), .qv(qv_b), .fill(fill_b), .full(full_b));
  vtdl_mt #(.WID(8), .DEP(16), .NTAP(2), .OREG(1)) u_c (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .d(d), .a(a_c),
    .q(q_c), .qv(qv_c), .fill(fill_c), .full(full_c));
  vtdl_mt #(.WID(8), .DEP(5), .NTAP(2), .OREG(0)) u_d (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .d(d), .a(a_d),
    .q(q_d), .qv(qv_d), .fill(fill_d), .full(full_d));

  always #5 clk = ~clk;

  int         nchk = 0;
  int         nerr = 0;
  exp_t       sb[$];
  int         dep[4] = '{16, 12, 16, 5};
  logic [7:0] hist[4][16];
  int         hlen[4] = '{0, 0, 0, 0};
  logic [7:0] creg_q[2] = '{8'h00, 8'h00};
  logic       creg_qv[2] = '{1'b0, 1'b0};

  logic       n_rst, n_ce, n_clr;
  logic [7:0] n_d;
  logic [3:0] n_a[4][2];

  function automatic int aval(int i, int k);
    case (i)
      0: return int'(a_a[k*4 +: 4]);
      1: return int'(a_b[k*4 +: 4]);
      2: return int'(a_c[k*4 +: 4]);
      default: return int'(a_d[k*3 +: 3]);
    endcase
  endfunction

  // Sample of age av, or zero when that age has not been written or is out of range.
  function automatic logic [8:0] tap(int i, int av);
    if (av < hlen[i] && av < dep[i])
      return {1'b1, hist[i][av]};
    return 9'd0;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic [8:0] t;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (i == 2) begin
          e.q[i][k]  = creg_q[k];
          e.qv[i][k] = creg_qv[k];
        end else begin
          t = tap(i, aval(i, k));
          e.qv[i][k] = t[8];
          e.q[i][k]  = t[7:0];
        end
      end
      e.fill[i] = 5'(hlen[i]);
      e.full[i] = (hlen[i] == dep[i]);
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) hlen[i] = 0;
    for (int k = 0; k < 2; k++) begin
      creg_q[k]  = 8'h00;
      creg_qv[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [8:0] t;
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int k = 0; k < 2; k++) begin
        t = tap(2, aval(2, k));
        creg_q[k]  = clr ? 8'h00 : t[7:0];
        creg_qv[k] = clr ? 1'b0 : t[8];
      end
      if (clr) begin
        for (int i = 0; i < 4; i++) hlen[i] = 0;
      end else if (ce) begin
        for (int i = 0; i < 4; i++) begin
          for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
          hist[i][0] = d;
          if (hlen[i] < dep[i]) hlen[i]++;
        end
      end
    end
  endtask

  // One clock: advance the model on the edge, drive next inputs, queue the expectation.
  task automatic cyc(input bit mid_rst = 1'b0);
    @(posedge clk);
    model_edge();
    #1;
    rst_n = n_rst;
    ce    = n_ce;
    clr   = n_clr;
    d     = n_d;
    a_a   = {n_a[0][1], n_a[0][0]};
    a_b   = {n_a[1][1], n_a[1][0]};
    a_c   = {n_a[2][1], n_a[2][0]};
    a_d   = {n_a[3][1][2:0], n_a[3][0][2:0]};
    if (mid_rst) begin
      #1;
      rst_n = 1'b0;
    end
    if (!rst_n) model_clear();
    sb.push_back(expect_now());
  endtask

  task automatic setall(input logic [3:0] t0, input logic [3:0] t1);
    for (int i = 0; i < 4; i++) begin
      n_a[i][0] = t0;
      n_a[i][1] = t1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: every sampled cycle is scored against the oldest queued expectation.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        act = '0;
        act.q[0] = q_a;  act.q[1] = q_b;  act.q[2] = q_c;  act.q[3] = q_d;
        act.qv[0] = qv_a; act.qv[1] = qv_b; act.qv[2] = qv_c; act.qv[3] = qv_d;
        act.fill[0] = fill_a; act.fill[1] = fill_b; act.fill[2] = fill_c;
        act.fill[3] = {1'b0, fill_d};
        act.full = {full_d, full_c, full_b, full_a};
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("u%0d.q", i), 32'(act.q[i]), 32'(e.q[i]));
          chk($sformatf("u%0d.qv", i), 32'(act.qv[i]), 32'(e.qv[i]));
          chk($sformatf("u%0d.fill", i), 32'(act.fill[i]), 32'(e.fill[i]));
          chk($sformatf("u%0d.full", i), 32'(act.full[i]), 32'(e.full[i]));
        end
      end
    end
  end

  initial begin
    n_rst = 1'b0; n_ce = 1'b0; n_clr = 1'b0; n_d = 8'h00;
    setall(4'd0, 4'd0);
    cyc(); cyc();
    n_rst = 1'b1;
    cyc();

    // Basic taps at ages 0 and 4, then an unwritten age.
    setall(4'd0, 4'd4);
    for (int v = 1; v <= 5; v++) begin
      n_ce = 1'b1; n_d = 8'(v); cyc();
    end
    n_ce = 1'b0; cyc();
    setall(4'd0, 4'd5); cyc();

    // Wrap and saturation, plus an out-of-range tap on the DEP=12 instance.
    n_clr = 1'b1; cyc(); n_clr = 1'b0;
    for (int v = 0; v < 20; v++) begin
      n_ce = 1'b1; n_d = 8'(v); cyc();
    end
    n_ce = 1'b0;
    n_a[0][0] = 4'd0;  n_a[0][1] = 4'd15;
    n_a[1][0] = 4'd13; n_a[1][1] = 4'd11;
    n_a[2][0] = 4'd0;  n_a[2][1] = 4'd15;
    n_a[3][0] = 4'd0;  n_a[3][1] = 4'd4;
    cyc(); cyc();

    // ce gating with d wandering.
    n_clr = 1'b1; cyc(); n_clr = 1'b0;
    setall(4'd0, 4'd2);
    for (int v = 0; v < 3; v++) begin
      n_ce = 1'b1; n_d = 8'hA0 + 8'(v); cyc();
    end
    n_ce = 1'b0;
    for (int r = 0; r < 5; r++) begin
      n_d = 8'($urandom); cyc();
    end

    // clr wins over ce, then a fresh write.
    setall(4'd0, 4'd1);
    n_ce = 1'b1; n_clr = 1'b1; n_d = 8'h55; cyc();
    n_clr = 1'b0; n_d = 8'h66; cyc();
    n_ce = 1'b0; cyc(); cyc();

    // Tap change seen a clk later on the registered instance, then async reset mid-cycle.
    n_clr = 1'b1; cyc(); n_clr = 1'b0;
    setall(4'd0, 4'd0);
    n_ce = 1'b1; n_d = 8'h10; cyc();
    n_d = 8'h20; cyc();
    n_ce = 1'b0; cyc(); cyc();
    setall(4'd1, 4'd1); cyc(); cyc();
    cyc(1'b1);
    n_rst = 1'b0; cyc();
    n_rst = 1'b1; cyc();

    // Non-power-of-two depth sweep.
    n_clr = 1'b1; cyc(); n_clr = 1'b0;
    for (int v = 1; v <= 7; v++) begin
      n_ce = 1'b1; n_d = 8'(v); cyc();
    end
    n_ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      setall(4'(k), 4'(4 - k)); cyc();
    end

    // Random traffic.
    for (int r = 0; r < 1000; r++) begin
      n_ce  = ($urandom_range(0, 3) != 0);
      n_clr = ($urandom_range(0, 19) == 0);
      n_d   = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
        n_a[i][0] = 4'($urandom_range(0, 15));
        n_a[i][1] = 4'($urandom_range(0, 15));
      end
      cyc();
    end
    n_ce = 1'b0; n_clr = 1'b0;
    cyc();

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
